// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants for the fetch queue.
// Default depth, address width and pointer-width helper.
package inst_fetch_queue_pkg;

  localparam int ADDR_SIZE = 32;
  localparam int FQ_DEPTH  = 4;
  localparam int FQ_PTR_W  = $clog2(FQ_DEPTH) + 1;

  // Pointer width: index bits plus a wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_fq_storage.sv
// Fetch queue entry storage: {addr, inst} register array.
// Independent addr-write, data-write and read ports.
module fq_storage #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              addr_we,
  input  logic [IDX_W-1:0]  addr_idx,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              data_we,
  input  logic [IDX_W-1:0]  data_idx,
  input  logic [DATA_W-1:0] data_in,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (addr_we) addr_mem[addr_idx] <= addr_in;
  end

  always_ff @(posedge clk) begin
    if (data_we) data_mem[data_idx] <= data_in;
  end

  assign rd_addr = addr_mem[rd_idx];
  assign rd_data = data_mem[rd_idx];

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch queue: forwards PC-stage requests to imem, buffers
// in-order responses for decode, drops stale beats after flush.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH  = FQ_DEPTH,
  parameter int ADDR_W = ADDR_SIZE,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              flush,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_inst,
  input  logic              out_ready
);

  localparam int PW = ptr_w(DEPTH);
  localparam int IW = PW - 1;

  logic [PW-1:0] alloc_ptr, fill_ptr, head_ptr, drop_cnt;
  logic [PW-1:0] used, pending, owed, owed_dec;
  logic [PW:0]   occ;
  logic          room, accept, fill, pop, drop_resp;

  assign used    = alloc_ptr - head_ptr;
  assign pending = alloc_ptr - fill_ptr;
  assign occ     = {1'b0, used} + {1'b0, drop_cnt};
  assign room    = occ < (PW+1)'(DEPTH);

  assign req_ready     = mem_req_ready & ~flush & room;
  assign mem_req_valid = req_valid & ~flush & room;
  assign mem_req_addr  = req_addr;

  assign accept    = req_valid & req_ready;
  assign drop_resp = mem_resp_valid & (drop_cnt != '0);
  assign fill      = mem_resp_valid & ~flush
                   & (drop_cnt == '0) & (pending != '0);
  assign out_valid = head_ptr != fill_ptr;
  assign pop       = out_valid & out_ready & ~flush;

  // Beats still owed by memory once the buffer is discarded.
  assign owed     = drop_cnt + pending;
  assign owed_dec = (mem_resp_valid && owed != '0)
                  ? owed - PW'(1) : owed;

  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      drop_cnt  <= '0;
    end else if (flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      drop_cnt  <= owed_dec;
    end else begin
      if (accept)    alloc_ptr <= alloc_ptr + PW'(1);
      if (fill)      fill_ptr  <= fill_ptr + PW'(1);
      if (pop)       head_ptr  <= head_ptr + PW'(1);
      if (drop_resp) drop_cnt  <= drop_cnt - PW'(1);
    end
  end

  fq_storage #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .IDX_W  (IW)
  ) u_storage (
    .clk      (clk),
    .addr_we  (accept),
    .addr_idx (alloc_ptr[IW-1:0]),
    .addr_in  (req_addr),
    .data_we  (fill),
    .data_idx (fill_ptr[IW-1:0]),
    .data_in  (mem_resp_data),
    .rd_idx   (head_ptr[IW-1:0]),
    .rd_addr  (out_addr),
    .rd_data  (out_inst)
  );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue.
// Handshake vectors, scoreboarded outputs, flush/full/wrap/reset cases.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready;
  logic        flush = 1'b0;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b1;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        out_valid;
  logic [31:0] out_addr;
  logic [31:0] out_inst;
  logic        out_ready = 1'b0;

  inst_fetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_ready      (req_ready),
    .flush          (flush),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .out_valid      (out_valid),
    .out_addr       (out_addr),
    .out_inst       (out_inst),
    .out_ready      (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic rv;
    logic mrdy;
    logic fl;
    logic exp_rdy;
    logic exp_mv;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h0000_0013;
  endfunction

  // Scoreboard: every pop decode would see is matched in order.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", out_addr, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_addr", out_addr, e.addr);
        chk("out_inst", out_inst, e.inst);
      end
    end
  end

  task automatic idle();
    req_valid      = 1'b0;
    flush          = 1'b0;
    mem_resp_valid = 1'b0;
    out_ready      = 1'b0;
    mem_req_ready  = 1'b1;
  endtask

  task automatic accept(input logic [31:0] a, input string name);
    req_valid = 1'b1;
    req_addr  = a;
    #1;
    chk(name, {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d, input logic keep,
                         input logic [31:0] a);
    mem_resp_valid = 1'b1;
    mem_resp_data  = d;
    if (keep) exp_q.push_back('{addr: a, inst: d});
    tick();
    mem_resp_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    out_ready = 1'b0;
    #1;
    chk({name, "_sb_empty"}, exp_q.size(), 0);
    chk({name, "_out_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Empty-queue handshake table; no clock edges in between.
    req_addr = 32'h8000_0abc;
    for (int i = 0; i < 8; i++) begin
      req_valid     = vecs[i].rv;
      mem_req_ready = vecs[i].mrdy;
      flush         = vecs[i].fl;
      #1;
      chk($sformatf("vec%0d_req_ready", i), {31'd0, req_ready},
          {31'd0, vecs[i].exp_rdy});
      chk($sformatf("vec%0d_mem_req_valid", i), {31'd0, mem_req_valid},
          {31'd0, vecs[i].exp_mv});
      if (vecs[i].exp_mv)
        chk($sformatf("vec%0d_mem_req_addr", i), mem_req_addr,
            32'h8000_0abc);
    end
    idle();

    // Stray response with nothing pending is ignored.
    respond(32'hDEAD_BEEF, 1'b0, 32'h0);
    #1;
    chk("stray_resp_ignored", {31'd0, out_valid}, 32'd0);

    // Single fetch, response two cycles after acceptance.
    accept(32'h8000_0000, "single_accept");
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_0013;
    exp_q.push_back('{addr: 32'h8000_0000, inst: 32'h0000_0013});
    #1;
    chk("single_no_bypass", {31'd0, out_valid}, 32'd0);
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("single_out_valid", {31'd0, out_valid}, 32'd1);
    chk("single_out_addr", out_addr, 32'h8000_0000);
    chk("single_out_inst", out_inst, 32'h0000_0013);
    drain("single");

    // Fill to capacity, then one pop frees a slot a cycle later.
    for (int i = 0; i < 4; i++)
      accept(32'h8000_0000 + 32'(4 * i), $sformatf("full_acc%0d", i));
    for (int i = 0; i < 4; i++)
      respond(mem_word(32'h8000_0000 + 32'(4 * i)), 1'b1,
              32'h8000_0000 + 32'(4 * i));
    req_valid = 1'b1;
    req_addr  = 32'h8000_0010;
    #1;
    chk("full_req_ready", {31'd0, req_ready}, 32'd0);
    chk("full_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    out_ready = 1'b1;
    #1;
    chk("full_pop_same_cycle", {31'd0, req_ready}, 32'd0);
    tick();
    out_ready = 1'b0;
    #1;
    chk("full_freed", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    respond(mem_word(32'h8000_0010), 1'b1, 32'h8000_0010);
    drain("full");

    // Flush with two requests in flight.
    accept(32'h8000_0020, "fl2_acc0");
    accept(32'h8000_0024, "fl2_acc1");
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h8000_0028;
    #1;
    chk("fl2_flush_req_ready", {31'd0, req_ready}, 32'd0);
    chk("fl2_flush_mem_valid", {31'd0, mem_req_valid}, 32'd0);
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("fl2_out_valid", {31'd0, out_valid}, 32'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hBAD0_0001;
    accept(32'h8000_0100, "fl2_new_accept");
    respond(32'hBAD0_0002, 1'b0, 32'h0);
    #1;
    chk("fl2_stale_dropped", {31'd0, out_valid}, 32'd0);
    respond(32'h0010_0093, 1'b1, 32'h8000_0100);
    #1;
    chk("fl2_new_valid", {31'd0, out_valid}, 32'd1);
    drain("fl2");

    // Flush coinciding with a response, three pending: two owed.
    accept(32'h8000_0200, "fl3_acc0");
    accept(32'h8000_0204, "fl3_acc1");
    accept(32'h8000_0208, "fl3_acc2");
    flush = 1'b1;
    respond(32'hBAD0_0003, 1'b0, 32'h0);
    flush = 1'b0;
    #1;
    chk("fl3_out_valid", {31'd0, out_valid}, 32'd0);
    accept(32'h8000_0300, "fl3_new0");
    accept(32'h8000_0304, "fl3_new1");
    req_valid = 1'b1;
    req_addr  = 32'h8000_0308;
    #1;
    chk("fl3_owed_two", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b0;
    respond(32'hBAD0_0004, 1'b0, 32'h0);
    respond(32'hBAD0_0005, 1'b0, 32'h0);
    #1;
    chk("fl3_stale_dropped", {31'd0, out_valid}, 32'd0);
    respond(mem_word(32'h8000_0300), 1'b1, 32'h8000_0300);
    respond(mem_word(32'h8000_0304), 1'b1, 32'h8000_0304);
    drain("fl3");

    // Streaming through several pointer wraps, 1-cycle memory.
    begin
      int          issued;
      int          first;
      int          last;
      logic        last_acc;
      logic [31:0] last_addr;
      issued   = 0;
      first    = -1;
      last     = -1;
      last_acc = 1'b0;
      last_addr = '0;
      for (int c = 0; c < 100; c++) begin
        req_valid      = issued < 20;
        req_addr       = 32'h8000_1000 + 32'(4 * issued);
        mem_resp_valid = last_acc;
        mem_resp_data  = mem_word(last_addr);
        if (last_acc)
          exp_q.push_back('{addr: last_addr, inst: mem_word(last_addr)});
        out_ready = 1'b1;
        #1;
        if (out_valid) begin
          if (first < 0) first = c;
          last = c;
        end
        last_acc  = req_valid && req_ready;
        last_addr = req_addr;
        if (last_acc) issued++;
        tick();
        if (issued == 20 && !last_acc && exp_q.size() == 0) break;
      end
      idle();
      chk("stream_issued", 32'(issued), 32'd20);
      chk("stream_sb_empty", exp_q.size(), 0);
      chk("stream_no_gaps", 32'(last - first + 1), 32'd20);
    end

    // Reset mid-stream with two filled entries; overrides flush.
    accept(32'h8000_0400, "rst_acc0");
    accept(32'h8000_0404, "rst_acc1");
    respond(mem_word(32'h8000_0400), 1'b0, 32'h0);
    respond(mem_word(32'h8000_0404), 1'b0, 32'h0);
    #1;
    chk("rst_mid_buffered", {31'd0, out_valid}, 32'd1);
    reset     = 1'b1;
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h8000_0408;
    tick();
    reset = 1'b0;
    idle();
    #1;
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    mem_req_ready = 1'b0;
    #1;
    chk("rst_mid_ready_lo", {31'd0, req_ready}, 32'd0);
    mem_req_ready = 1'b1;
    #1;
    chk("rst_mid_ready_hi", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 4; i++)
      accept(32'h8000_0500 + 32'(4 * i), $sformatf("rst_cap%0d", i));
    req_valid = 1'b1;
    #1;
    chk("rst_cap_full", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++)
      respond(mem_word(32'h8000_0500 + 32'(4 * i)), 1'b1,
              32'h8000_0500 + 32'(4 * i));
    drain("rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
